// File: rtl/cache_mem_responder.sv
// Backing-memory responder for the data cache: single-word reads and write-throughs,
// each answered after a fixed LATENCY over valid/ready request and response channels.
module cache_mem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned LATENCY     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  state_t                  state;
  logic [3:0]              count;
  logic                    we_q;
  logic [INDEX_WIDTH-1:0]  index_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   mem [2**INDEX_WIDTH];
  logic                    commit;

  // Byte offset and high address bits are deliberately dropped: word access with aliasing.
  logic unused_addr;
  assign unused_addr = ^{req_addr[ADDR_WIDTH-1:INDEX_WIDTH+2], req_addr[1:0]};

  assign commit    = (state == WAIT) && (count == 4'd0);
  // Combinational so that ready drops in the very cycle reset is asserted.
  assign req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 4'd0;
      we_q       <= 1'b0;
      index_q    <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            index_q <= req_addr[INDEX_WIDTH+1:2];
            wdata_q <= req_wdata;
            count   <= COUNT_LOAD;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            resp_rdata <= we_q ? wdata_q : mem[index_q];
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; rst only gates the commit so reset wins on a tie.
  always_ff @(posedge clk) begin
    if (!rst && commit && we_q) begin
      mem[index_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: a LATENCY=3 and a LATENCY=1 instance share
// clock and reset; expected responses are queued at acceptance and checked on handshake.
module tb_cache_mem_responder;

  localparam int LAT [2] = '{3, 1};

  typedef struct {
    int          d;
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = '0;
  logic [31:0] req_addr  [2] = '{32'h0, 32'h0};
  logic [31:0] req_wdata [2] = '{32'h0, 32'h0};
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready = '0;
  logic [31:0] resp_rdata [2];

  exp_t exp_q [$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  logic [1:0] prev_v = '0;
  logic [1:0] chk_rdy = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_mem_responder #(.LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0])
  );

  cache_mem_responder #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Response monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (chk_rdy[d]) begin
        check($sformatf("ready_after_consume%0d", d), 32'(req_ready[d]), 32'd1);
        chk_rdy[d] = 1'b0;
      end
      if (resp_valid[d] && !prev_v[d]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_resp%0d", d), 32'd1, 32'd0);
        end else begin
          check($sformatf("latency%0d", d), 32'(cyc - exp_q[0].acc), 32'(LAT[d]));
        end
      end
      if (resp_valid[d] && resp_ready[d] && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("resp_dut%0d", d), 32'(e.d), 32'(d));
        check($sformatf("rdata%0d", d), resp_rdata[d], e.data);
        chk_rdy[d] = 1'b1;
      end
      prev_v[d] = resp_valid[d];
    end
  end

  // Presents a request from posedge+1 and returns the edge number at which it was accepted.
  task automatic send(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp, output int acc);
    int n = 0;
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(negedge clk);
    while (!req_ready[d] && n <= 100) begin
      n++;
      @(negedge clk);
    end
    acc = cyc + 1;
    if (n > 100) check("accept_timeout", 32'd0, 32'd1);
    else exp_q.push_back('{d: d, data: exp, acc: acc});
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 200) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    repeat (ncyc) begin
      @(negedge clk);
      check("ready_in_rst0", 32'(req_ready[0]), 32'd0);
      check("ready_in_rst1", 32'(req_ready[1]), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_valid%0d", d), 32'(resp_valid[d]), 32'd0);
      check($sformatf("rst_rdata%0d", d), resp_rdata[d], 32'd0);
      check($sformatf("rst_ready%0d", d), 32'(req_ready[d]), 32'd1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev_acc, n;
    logic [31:0] words [8];

    @(posedge clk); #1;
    do_reset(2);
    resp_ready = 2'b11;

    // Write then read on the LATENCY=3 instance.
    send(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, acc);
    drain();
    send(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, acc);
    drain();

    // Mid-idle reset clears the response register, which now holds a nonzero word.
    do_reset(2);

    // Aliasing and byte-offset masking.
    send(0, 1'b1, 32'h0000_1004, 32'h1234_5678, 32'h1234_5678, acc);
    send(0, 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, acc);
    send(0, 1'b0, 32'h0000_0007, 32'hFFFF_FFFF, 32'h1234_5678, acc);
    drain();

    // Backpressure: response held for 5 cycles while another request waits.
    send(0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'hCAFE_F00D, acc);
    drain();
    resp_ready[0] = 1'b0;
    send(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, acc);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 32'h0000_0040;
    n = 0;
    @(negedge clk);
    while (!resp_valid[0] && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("bp_valid_seen", 32'(resp_valid[0]), 32'd1);
    repeat (5) begin
      check("bp_valid", 32'(resp_valid[0]), 32'd1);
      check("bp_rdata", resp_rdata[0], 32'hDEAD_BEEF);
      check("bp_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    send(0, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, acc);
    drain();

    // Reset one cycle after a write is accepted: the write must not commit.
    send(0, 1'b1, 32'h0000_0020, 32'h0, 32'h0, acc);
    drain();
    send(0, 1'b1, 32'h0000_0020, 32'hAAAA_5555, 32'hAAAA_5555, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_valid", 32'(resp_valid[0]), 32'd0);
    check("midrst_ready", 32'(req_ready[0]), 32'd1);
    repeat (4) @(negedge clk);
    check("midrst_no_resp", 32'(resp_valid[0]), 32'd0);
    @(posedge clk); #1;
    send(0, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0000, acc);
    drain();

    // LATENCY=1 instance: back-to-back writes then reads of 8 consecutive words.
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      send(1, 1'b1, 32'h0000_0100 + 32'(4 * i), words[i], words[i], acc);
      if (i > 0) check("wr_interval", 32'(acc - prev_acc), 32'd3);
      prev_acc = acc;
    end
    for (int i = 0; i < 8; i++) begin
      send(1, 1'b0, 32'h0000_0100 + 32'(4 * i), 32'h0, words[i], acc);
      if (i > 0) check("rd_interval", 32'(acc - prev_acc), 32'd3);
      prev_acc = acc;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
